// File: rtl/fp_pkg.sv
// Shared single-precision FP definitions for the divider and multiplier datapath.
package fp_pkg;

    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MAN_W   = 23;
    localparam int unsigned SIG_W   = MAN_W + 1;
    localparam int unsigned QBITS   = 25;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned REM_W   = 26;
    localparam int unsigned TRIAL_W = REM_W + 1;
    localparam int unsigned E_W     = 10;
    localparam int          BIAS    = 127;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;
    typedef enum logic [1:0] {ZERO, INF, NAN, NORMAL} fp_class_t;

    function automatic logic [31:0] pack_fp(input logic s, input logic [EXP_W-1:0] e,
                                            input logic [MAN_W-1:0] m);
        return {s, e, m};
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits an IEEE single into sign, exponent, significand with hidden bit, and class.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0]      word,
    output logic             sign,
    output logic [EXP_W-1:0] exp,
    output logic [SIG_W-1:0] sig,
    output fp_class_t        cls
);

    logic [MAN_W-1:0] man;

    assign sign = word[31];
    assign exp  = word[30:23];
    assign man  = word[MAN_W-1:0];
    assign sig  = {1'b1, man};

    // Denormals share the zero class so they are flushed.
    always_comb begin
        cls = NORMAL;
        if (exp == '0)
            cls = ZERO;
        else if (exp == '1)
            cls = (man == '0) ? INF : NAN;
    end

endmodule

// File: rtl/ieee_divide_seq.sv
// Sequential single-precision divider: one restoring quotient bit per clock, truncating.
module ieee_divide_seq
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] c,
    output logic        div_by_zero,
    output logic        invalid
);

    logic             sa, sb;
    logic [EXP_W-1:0] xa, xb;
    logic [SIG_W-1:0] ga, gb;
    fp_class_t        ka, kb;

    fp_unpack u_unpack_a (.word(a), .sign(sa), .exp(xa), .sig(ga), .cls(ka));
    fp_unpack u_unpack_b (.word(b), .sign(sb), .exp(xb), .sig(gb), .cls(kb));

    state_t           state;
    logic             sign;
    logic [EXP_W-1:0] ea, eb;
    logic [REM_W-1:0] rem;
    logic [SIG_W-1:0] divisor;
    logic [QBITS-1:0] q;
    logic [CNT_W-1:0] count;
    logic             special;
    logic [31:0]      spec_res;
    logic             spec_dbz, spec_inv;

    logic             is_special_c;
    logic [31:0]      sp_res_c;
    logic             sp_dbz_c, sp_inv_c;
    logic [TRIAL_W-1:0] trial_c;
    logic             ge_c;
    logic signed [E_W-1:0] e_c;
    logic [MAN_W-1:0] mant_c;
    logic [31:0]      norm_res_c;

    // Special-operand result selection, highest priority first.
    always_comb begin
        is_special_c = (ka != NORMAL) || (kb != NORMAL);
        sp_res_c     = pack_fp(sa ^ sb, '0, '0);
        sp_dbz_c     = 1'b0;
        sp_inv_c     = 1'b0;
        if (ka == NAN || kb == NAN || (ka == ZERO && kb == ZERO) || (ka == INF && kb == INF)) begin
            sp_res_c = QNAN;
            sp_inv_c = 1'b1;
        end else if (kb == ZERO && ka == NORMAL) begin
            sp_res_c = {sa ^ sb, POS_INF[30:0]};
            sp_dbz_c = 1'b1;
        end else if (ka == INF) begin
            sp_res_c = {sa ^ sb, POS_INF[30:0]};
        end
    end

    assign trial_c = {1'b0, rem} - TRIAL_W'(divisor);
    assign ge_c    = ~trial_c[TRIAL_W-1];

    // Quotient in [0.5,2): a leading zero costs one exponent step.
    assign e_c    = $signed(E_W'(ea) - E_W'(eb) + E_W'(q[QBITS-1] ? BIAS : BIAS - 1));
    assign mant_c = q[QBITS-1] ? q[QBITS-2:1] : q[QBITS-3:0];

    always_comb begin
        norm_res_c = pack_fp(sign, e_c[EXP_W-1:0], mant_c);
        if (e_c >= 10'sd255)
            norm_res_c = {sign, POS_INF[30:0]};
        else if (e_c <= 10'sd0)
            norm_res_c = pack_fp(sign, '0, '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            c           <= '0;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy        <= 1'b1;
                    div_by_zero <= 1'b0;
                    invalid     <= 1'b0;
                    sign        <= sa ^ sb;
                    ea          <= xa;
                    eb          <= xb;
                    rem         <= REM_W'(ga);
                    divisor     <= gb;
                    q           <= '0;
                    count       <= '0;
                    special     <= is_special_c;
                    spec_res    <= sp_res_c;
                    spec_dbz    <= sp_dbz_c;
                    spec_inv    <= sp_inv_c;
                    state       <= DIV;
                end
                DIV: if (special) begin
                    c           <= spec_res;
                    div_by_zero <= spec_dbz;
                    invalid     <= spec_inv;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end else begin
                    rem   <= ge_c ? (trial_c[REM_W-1:0] << 1) : (rem << 1);
                    q     <= {q[QBITS-2:0], ge_c};
                    count <= count + 1'b1;
                    if (count == CNT_W'(QBITS - 1))
                        state <= NORM;
                end
                NORM: begin
                    c     <= norm_res_c;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ieee_divide_seq.sv
// Directed bench for ieee_divide_seq: hand-computed quotients, specials, handshake and reset.
module tb_ieee_divide_seq;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] a, b, c;
    logic        busy, done, div_by_zero, invalid;

    int vectors     = 0;
    int miscompares = 0;

    ieee_divide_seq dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .c(c),
        .div_by_zero(div_by_zero), .invalid(invalid)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts edges until done, bounded; ok drops if busy falls before done.
    task automatic wait_done(output int n, output logic ok);
        n  = 0;
        ok = 1'b1;
        while (done !== 1'b1 && n < 60) begin
            if (busy !== 1'b1) ok = 1'b0;
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input int cycles, input logic [31:0] exp_c,
                          input logic exp_dbz, input logic exp_inv);
        int   n;
        logic ok;
        a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " accept"}, {29'd0, busy, done, div_by_zero | invalid}, 32'h4);
        wait_done(n, ok);
        check({tag, " latency"}, 32'(n + 1), 32'(cycles));
        check({tag, " busy_hold"}, {31'd0, ok}, 32'h1);
        check({tag, " result"}, c, exp_c);
        check({tag, " flags"}, {30'd0, div_by_zero, invalid}, {30'd0, exp_dbz, exp_inv});
        check({tag, " busy_at_done"}, {31'd0, busy}, 32'h0);
        tick();
        check({tag, " done_pulse"}, {30'd0, busy, done}, 32'h0);
        check({tag, " c_hold"}, c, exp_c);
    endtask

    initial begin
        int   n;
        logic ok;
        int   seen;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        tick(); tick();
        check("reset_ctrl", {28'd0, busy, done, div_by_zero, invalid}, 32'h0);
        check("reset_c", c, 32'h0);
        rst = 1'b0;
        tick();

        run_op("64/2",     32'h42800000, 32'h40000000, 27, 32'h42000000, 1'b0, 1'b0);
        run_op("1/3",      32'h3F800000, 32'h40400000, 27, 32'h3EAAAAAA, 1'b0, 1'b0);
        run_op("-6/2",     32'hC0C00000, 32'h40000000, 27, 32'hC0400000, 1'b0, 1'b0);
        run_op("overflow", 32'h7F000000, 32'h3F000000, 27, 32'h7F800000, 1'b0, 1'b0);
        run_op("underflow",32'h00800000, 32'h40000000, 27, 32'h00000000, 1'b0, 1'b0);

        run_op("1/0",      32'h3F800000, 32'h00000000, 2, 32'h7F800000, 1'b1, 1'b0);
        run_op("0/0",      32'h00000000, 32'h00000000, 2, 32'h7FC00000, 1'b0, 1'b1);
        run_op("inf/inf",  32'h7F800000, 32'h7F800000, 2, 32'h7FC00000, 1'b0, 1'b1);
        run_op("nan/2",    32'h7FC00000, 32'h40000000, 2, 32'h7FC00000, 1'b0, 1'b1);
        run_op("x/inf",    32'h01000000, 32'h7F800000, 2, 32'h00000000, 1'b0, 1'b0);
        run_op("-4/-0.5",  32'hC0800000, 32'hBF000000, 27, 32'h41000000, 1'b0, 1'b0);

        // start held high, operands changed while busy
        a = 32'h42800000; b = 32'h40000000; start = 1'b1;
        tick();
        repeat (3) tick();
        a = 32'h3F800000; b = 32'h40400000;
        wait_done(n, ok);
        check("held latency", 32'(n + 4), 32'd27);
        check("held busy_hold", {31'd0, ok}, 32'h1);
        check("held result1", c, 32'h42000000);
        tick();
        start = 1'b0;
        check("held b2b_accept", {30'd0, busy, done}, 32'h2);
        wait_done(n, ok);
        check("held latency2", 32'(n + 1), 32'd27);
        check("held result2", c, 32'h3EAAAAAA);
        tick();

        // reset during a division
        a = 32'h42800000; b = 32'h40000000; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort ctrl", {28'd0, busy, done, div_by_zero, invalid}, 32'h0);
        check("abort c", c, 32'h0);
        seen = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen = 1;
        end
        check("abort no_done", 32'(seen), 32'd0);
        run_op("after_abort", 32'h3F800000, 32'h40400000, 27, 32'h3EAAAAAA, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
